processor_pin_poller: RTL and testbench

Sequencer and event controller for the 4-bit input PIO slave. Polls the PIO's data register over its Avalon-MM slave port at a fixed rate, debounces the sampled vector, latches rising edges into a sticky capture register and raises an interrupt. It presents a second Avalon-MM slave to the processor, so software reads clean state and edge events instead of raw pins.

---
 rtl/processor_pin_poller_pkg.sv | 18 +
 rtl/processor_pin_poller_if.sv | 36 +++
 rtl/processor_pin_poller_debounce.sv | 59 +++++
 rtl/processor_pin_poller.sv | 119 +++++++++++
 tb/tb_processor_pin_poller.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/processor_pin_poller_pkg.sv
// Shared constants and types for the PIO pin poller.
// Holds CPU register map, PIO address and FSM state encoding.
package processor_pin_poller_pkg;

  localparam logic [1:0] REG_STABLE = 2'd0;
  localparam logic [1:0] REG_MASK   = 2'd1;
  localparam logic [1:0] REG_EDGE   = 2'd2;
  localparam logic [1:0] REG_RAW    = 2'd3;

  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_CAP
  } state_e;

endpackage

// File: rtl/processor_pin_poller_if.sv
// Bus bundle: PIO-facing master port plus CPU-facing slave port.
// slave = poller side, master = environment (CPU + PIO) side.
interface processor_pin_poller_if;

  logic [1:0]  pio_address;
  logic [31:0] pio_readdata;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport slave (
    output pio_address,
    output readdata,
    output irq,
    input  pio_readdata,
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata
  );

  modport master (
    input  pio_address,
    input  readdata,
    input  irq,
    output pio_readdata,
    output address,
    output chipselect,
    output write_n,
    output writedata
  );

endinterface

// File: rtl/processor_pin_poller_debounce.sv
// Whole-vector debouncer: cap_i qualifies sample_i; stable_o is the
// accepted value, rise_o pulses new rising bits on a stable update.
module processor_pin_poller_debounce #(
  parameter int WIDTH    = 4,
  parameter int DEBOUNCE = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cap_i,
  input  logic [WIDTH-1:0] sample_i,
  output logic [WIDTH-1:0] stable_o,
  output logic [WIDTH-1:0] rise_o
);

  localparam int CW = $clog2(DEBOUNCE);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE - 1);

  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_inc;

  assign cnt_inc = (cnt_q == CMAX) ? CMAX : cnt_q + CW'(1);

  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_o   = '0;
    if (cap_i) begin
      if (sample_i != cand_q) begin
        cand_d = sample_i;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_inc;
        // Saturated count re-commits the same value: rise stays 0.
        if (cnt_inc == CMAX) begin
          stable_d = cand_q;
          rise_o   = cand_q & ~stable_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/processor_pin_poller.sv
// Polls the input PIO, debounces, captures rising edges, raises irq.
// Ports: clk, reset_n, bus (PIO master + CPU slave, see _if).
module processor_pin_poller
  import processor_pin_poller_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int POLL_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  processor_pin_poller_if.slave  bus
);

  localparam int TW = $clog2(POLL_DIV);
  localparam logic [TW-1:0] TMAX = TW'(POLL_DIV - 1);

  state_e state_q, state_d;

  logic [TW-1:0]    tmr_q, tmr_d;
  logic             tmr_last;
  logic             cap;
  logic [WIDTH-1:0] sample;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise;

  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] raw_q, raw_d;
  logic [WIDTH-1:0] clr;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q, irq_d;
  logic             wr, rd;

  logic unused_bits;
  assign unused_bits = ^{bus.pio_readdata[31:WIDTH],
                         bus.writedata[31:WIDTH]};

  assign sample   = bus.pio_readdata[WIDTH-1:0];
  assign tmr_last = (tmr_q == TMAX);
  assign tmr_d    = tmr_last ? '0 : tmr_q + TW'(1);

  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    unique case (state_q)
      ST_IDLE: if (tmr_last) state_d = ST_REQ;
      ST_REQ:  state_d = ST_CAP;
      ST_CAP: begin
        cap     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  processor_pin_poller_debounce #(
    .WIDTH    (WIDTH),
    .DEBOUNCE (DEBOUNCE)
  ) u_deb (
    .clk      (clk),
    .reset_n  (reset_n),
    .cap_i    (cap),
    .sample_i (sample),
    .stable_o (stable),
    .rise_o   (rise)
  );

  assign wr = bus.chipselect & ~bus.write_n;
  assign rd = bus.chipselect & bus.write_n;

  always_comb begin
    mask_d  = mask_q;
    clr     = '0;
    rdata_d = '0;
    if (wr && bus.address == REG_MASK)
      mask_d = bus.writedata[WIDTH-1:0];
    if (wr && bus.address == REG_EDGE)
      clr = bus.writedata[WIDTH-1:0];
    // Set applied after clear so a same-cycle edge survives.
    edge_d = (edge_q & ~clr) | rise;
    raw_d  = cap ? sample : raw_q;
    irq_d  = |(edge_q & mask_q);
    if (rd) begin
      unique case (1'b1)
        bus.address == REG_STABLE: rdata_d = 32'(stable);
        bus.address == REG_MASK:   rdata_d = 32'(mask_q);
        bus.address == REG_EDGE:   rdata_d = 32'(edge_q);
        bus.address == REG_RAW:    rdata_d = 32'(raw_q);
        default:                   rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      mask_q  <= '0;
      edge_q  <= '0;
      raw_q   <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      mask_q  <= mask_d;
      edge_q  <= edge_d;
      raw_q   <= raw_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign bus.pio_address = PIO_DATA_ADDR;
  assign bus.readdata    = rdata_q;
  assign bus.irq         = irq_q;

endmodule

// File: tb/tb_processor_pin_poller.sv
// Directed bench for processor_pin_poller (POLL_DIV=8, DEBOUNCE=3).
// Cycle k = k-th clock period after reset release; CAPs at 9,17,25,...
module tb_processor_pin_poller;
  import processor_pin_poller_pkg::*;

  localparam int PD = 8;
  localparam int DB = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  in_port = 4'h0;
  logic [31:0] d;
  int          cyc;
  int          checks = 0;
  int          errors = 0;

  processor_pin_poller_if bus();

  processor_pin_poller #(
    .WIDTH    (4),
    .POLL_DIV (PD),
    .DEBOUNCE (DB)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // PIO model: data register with 1-cycle registered readdata.
  always @(posedge clk or negedge reset_n)
    if (!reset_n) bus.pio_readdata <= '0;
    else bus.pio_readdata <= {28'b0, in_port};

  always @(posedge clk or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else cyc <= cyc + 1;

  task automatic goto(input int k);
    int n;
    n = 0;
    while (cyc != k && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (cyc != k) begin
      checks++;
      errors++;
      $display("FAIL goto: at cycle %0d, wanted %0d", cyc, k);
    end
  endtask

  task automatic cpu_read(input logic [1:0] a,
                          output logic [31:0] v);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    @(negedge clk);
    v = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic cpu_write(input logic [1:0] a,
                           input logic [31:0] w);
    bus.address    = a;
    bus.writedata  = w;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    in_port = 4'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.readdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_rdata: got %0h want 0", bus.readdata);
    end
    checks++;
    if (bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL rst_irq: got %0b want 0", bus.irq);
    end
    checks++;
    if (bus.pio_address !== 2'd0) begin
      errors++;
      $display("FAIL rst_pioaddr: got %0h want 0", bus.pio_address);
    end
    reset_n = 1'b1;
    goto(2);
    cpu_read(REG_RAW, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL raw_init: got %0h want 0", d);
    end
    goto(5);
    checks++;
    if (bus.readdata !== 32'h0) begin
      errors++;
      $display("FAIL idle_rdata: got %0h want 0", bus.readdata);
    end
    goto(8);
    checks++;
    if (bus.pio_address !== 2'd0) begin
      errors++;
      $display("FAIL req_pioaddr: got %0h want 0", bus.pio_address);
    end
  endtask

  task automatic test_glitch;
    goto(26);
    in_port = 4'h8;
    goto(34);
    in_port = 4'h0;
    cpu_read(REG_RAW, d);
    checks++;
    if (d !== 32'h8) begin
      errors++;
      $display("FAIL glitch_raw: got %0h want 8", d);
    end
    goto(36);
    cpu_read(REG_STABLE, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL glitch_stable: got %0h want 0", d);
    end
    goto(42);
    cpu_read(REG_RAW, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL glitch_raw0: got %0h want 0", d);
    end
    goto(43);
    cpu_read(REG_EDGE, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL glitch_edge: got %0h want 0", d);
    end
  endtask

  task automatic test_step;
    goto(44);
    cpu_write(REG_MASK, 32'hFFFF_FFF1);
    goto(46);
    cpu_read(REG_MASK, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL mask_rd: got %0h want 1", d);
    end
    goto(48);
    cpu_write(REG_STABLE, 32'hF);
    goto(50);
    in_port = 4'h5;
    goto(51);
    cpu_read(REG_STABLE, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL ro_write: got %0h want 0", d);
    end
    goto(66);
    cpu_read(REG_STABLE, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL step_early: got %0h want 0", d);
    end
    goto(74);
    checks++;
    if (bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_lat: got %0b want 0", bus.irq);
    end
    goto(75);
    checks++;
    if (bus.irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_set: got %0b want 1", bus.irq);
    end
    goto(76);
    cpu_read(REG_STABLE, d);
    checks++;
    if (d !== 32'h5) begin
      errors++;
      $display("FAIL step_stable: got %0h want 5", d);
    end
    goto(78);
    cpu_read(REG_EDGE, d);
    checks++;
    if (d !== 32'h5) begin
      errors++;
      $display("FAIL step_edge: got %0h want 5", d);
    end
  endtask

  task automatic test_clear;
    goto(80);
    cpu_write(REG_EDGE, 32'h4);
    goto(82);
    cpu_read(REG_EDGE, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL clr4_edge: got %0h want 1", d);
    end
    goto(84);
    checks++;
    if (bus.irq !== 1'b1) begin
      errors++;
      $display("FAIL clr4_irq: got %0b want 1", bus.irq);
    end
    goto(85);
    cpu_write(REG_EDGE, 32'h1);
    checks++;
    if (bus.irq !== 1'b1) begin
      errors++;
      $display("FAIL clr1_irq_lag: got %0b want 1", bus.irq);
    end
    goto(87);
    checks++;
    if (bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL clr1_irq: got %0b want 0", bus.irq);
    end
    goto(88);
    cpu_read(REG_EDGE, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL clr1_edge: got %0h want 0", d);
    end
  endtask

  task automatic test_back_to_back;
    goto(90);
    in_port = 4'h4;
    goto(114);
    in_port = 4'h5;
    cpu_read(REG_STABLE, d);
    checks++;
    if (d !== 32'h4) begin
      errors++;
      $display("FAIL fall_stable: got %0h want 4", d);
    end
    goto(116);
    cpu_read(REG_EDGE, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL fall_edge: got %0h want 0", d);
    end
    goto(137);
    cpu_write(REG_EDGE, 32'h1);
    goto(139);
    cpu_read(REG_EDGE, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL setwins_edge: got %0h want 1", d);
    end
    goto(141);
    checks++;
    if (bus.irq !== 1'b1) begin
      errors++;
      $display("FAIL setwins_irq: got %0b want 1", bus.irq);
    end
  endtask

  task automatic test_reset_mid;
    goto(144);
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL mid_irq: got %0b want 0", bus.irq);
    end
    checks++;
    if (bus.readdata !== 32'h0) begin
      errors++;
      $display("FAIL mid_rdata: got %0h want 0", bus.readdata);
    end
    checks++;
    if (bus.pio_address !== 2'd0) begin
      errors++;
      $display("FAIL mid_pioaddr: got %0h want 0", bus.pio_address);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    goto(2);
    cpu_read(REG_MASK, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL mid_mask: got %0h want 0", d);
    end
    goto(4);
    cpu_read(REG_EDGE, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL mid_edge: got %0h want 0", d);
    end
    goto(8);
    cpu_read(REG_RAW, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL mid_raw_pre: got %0h want 0", d);
    end
    goto(10);
    cpu_read(REG_RAW, d);
    checks++;
    if (d !== 32'h5) begin
      errors++;
      $display("FAIL mid_raw_cap: got %0h want 5", d);
    end
    goto(18);
    cpu_read(REG_STABLE, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL mid_stable2: got %0h want 0", d);
    end
    goto(26);
    cpu_read(REG_STABLE, d);
    checks++;
    if (d !== 32'h5) begin
      errors++;
      $display("FAIL mid_stable3: got %0h want 5", d);
    end
    goto(28);
    checks++;
    if (bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL mid_irq_mask0: got %0b want 0", bus.irq);
    end
    goto(29);
    cpu_read(REG_EDGE, d);
    checks++;
    if (d !== 32'h5) begin
      errors++;
      $display("FAIL mid_edge5: got %0h want 5", d);
    end
  endtask

  initial begin
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
    test_reset();
    test_glitch();
    test_step();
    test_clear();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t, limit 100000", $time);
    $fatal(1, "watchdog");
  end

endmodule
